// File: rtl/midi_pkg.sv
// Shared MIDI decoder definitions: status type codes, parser states and the
// byte value at which realtime messages begin.
package midi_pkg;

  localparam logic [2:0] NOTE_OFF = 3'h0;
  localparam logic [2:0] NOTE_ON  = 3'h1;
  localparam logic [2:0] POLY_AT  = 3'h2;
  localparam logic [2:0] CC       = 3'h3;
  localparam logic [2:0] PROG     = 3'h4;
  localparam logic [2:0] CH_AT    = 3'h5;
  localparam logic [2:0] PITCH    = 3'h6;

  localparam logic [7:0] RT_THRESHOLD = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    DATA1,
    DATA2
  } state_t;

endpackage

// File: rtl/midi_decoder.sv
// Single-channel MIDI channel-voice parser feeding the nco: monophonic,
// last-note-wins note state plus program, with running status and SysEx skip.
module midi_decoder
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] note_num,
  output logic [6:0] note_vel,
  output logic [6:0] program_num,
  output logic       update
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  state_t     state, state_d;
  logic [2:0] type_q, type_d;
  logic       match_q, match_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] num_d, vel_d, prog_d;
  logic       upd_d;

  logic       is_rt, is_syscom, is_chan;
  logic       done;
  logic [6:0] c_d1, c_d2;

  assign is_rt     = (rx_data >= RT_THRESHOLD);
  assign is_syscom = (rx_data[7:4] == 4'hF) && !is_rt;
  assign is_chan   = rx_data[7] && (rx_data[7:4] != 4'hF);

  always_comb begin
    state_d = state;
    type_d  = type_q;
    match_d = match_q;
    d1_d    = d1_q;
    num_d   = note_num;
    vel_d   = note_vel;
    prog_d  = program_num;
    upd_d   = 1'b0;
    done    = 1'b0;
    c_d1    = d1_q;
    c_d2    = '0;

    if (rx_valid && !is_rt) begin
      if (is_syscom) begin
        state_d = IDLE;
      end else if (is_chan) begin
        type_d  = rx_data[6:4];
        match_d = (rx_data[3:0] == CH);
        state_d = DATA1;
      end else begin
        case (state)
          DATA1: begin
            d1_d = rx_data[6:0];
            if (type_q == PROG || type_q == CH_AT) begin
              done = 1'b1;
              c_d1 = rx_data[6:0];
            end else begin
              state_d = DATA2;
            end
          end
          DATA2: begin
            done    = 1'b1;
            c_d2    = rx_data[6:0];
            state_d = DATA1;
          end
          default: ;
        endcase
      end
    end

    // Note-on with zero velocity is folded into the note-off path.
    if (done && match_q) begin
      if (type_q == NOTE_ON && c_d2 != '0) begin
        num_d = c_d1;
        vel_d = c_d2;
        upd_d = 1'b1;
      end else if (type_q == NOTE_ON || type_q == NOTE_OFF) begin
        if (c_d1 == note_num) begin
          vel_d = '0;
          upd_d = 1'b1;
        end
      end else if (type_q == PROG) begin
        prog_d = c_d1;
        upd_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      type_q      <= '0;
      match_q     <= 1'b0;
      d1_q        <= '0;
      note_num    <= '0;
      note_vel    <= '0;
      program_num <= '0;
      update      <= 1'b0;
    end else begin
      state       <= state_d;
      type_q      <= type_d;
      match_q     <= match_d;
      d1_q        <= d1_d;
      note_num    <= num_d;
      note_vel    <= vel_d;
      program_num <= prog_d;
      update      <= upd_d;
    end
  end

endmodule
